servo_pwm_capture: RTL and testbench
====================================

SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

Interface
REQ-001 The block SHALL have parameter GLITCH_CLKS, default 4, giving the consecutive equal synced samples needed to accept a level change (used only with the filter macro).
REQ-002 The block SHALL have parameter TIMEOUT_UI, default 40000, giving the pulse_ui ticks without a rising edge before timeout.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port cap_en, input, 1, capture enable.
REQ-006 The block SHALL have port pulse_ui, input, 1, one-clk unit-interval tick strobe.
REQ-007 The block SHALL have port pwm_pin, input, 1, asynchronous servo PWM input.
REQ-008 The block SHALL have port cap_active, output, 1, high while in HIGH or LOW state.
REQ-009 The block SHALL have port cap_valid, output, 1, one-clk strobe when a full frame is measured.
REQ-010 The block SHALL have port cap_pulse_width_ui, output, 12, high time of the last full frame in ui.
REQ-011 The block SHALL have port cap_period_ui, output, 16, rise-to-rise period of the last full frame in ui.
REQ-012 The block SHALL have port cap_timeout, output, 1, level: no rising edge within TIMEOUT_UI.
REQ-013 The block SHALL have port cap_error, output, 1, sticky: width or period counter saturated.

Function
REQ-014 pwm_pin SHALL pass a 2-FF synchronizer; rise/fall events SHALL be detected against a registered copy of the synced level, giving 3 clk from pin edge to event.
REQ-015 FSM states SHALL be IDLE, ARM, WAIT_RISE, HIGH, LOW.
REQ-016 IDLE->ARM when cap_en=1; ARM->WAIT_RISE when synced level=0, so a pulse already in progress at enable is never measured.
REQ-017 WAIT_RISE->HIGH on rise; width and period counters load 0 on that cycle, any coincident pulse_ui tick discarded.
REQ-018 In HIGH each pulse_ui SHALL increment width (saturate 4095) and period (saturate 65535); on fall -> LOW, width counter held.
REQ-019 In LOW each pulse_ui SHALL increment period; on rise: cap_pulse_width_ui and cap_period_ui load the counters, cap_valid=1 for exactly that one clk, counters reload 0, state -> HIGH.
REQ-020 Any counter reaching saturation SHALL set cap_error; it clears only on cap_en=0 or reset.
REQ-021 Period counter also SHALL count in WAIT_RISE; reaching TIMEOUT_UI in WAIT_RISE/HIGH/LOW SHALL set cap_timeout, clear counters, go ARM; cap_timeout clears on next cap_valid or cap_en=0.
REQ-022 cap_en=0 in any state SHALL go IDLE next clk, clear counters, cap_timeout, cap_error, suppress cap_valid; measurement outputs hold last values.
REQ-023 Rise and fall on the same clk are impossible after sync; rise with timeout on the same clk: rise wins.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, sync flops 0, all counters 0, cap_active/cap_valid/cap_timeout/cap_error 0, cap_pulse_width_ui=0, cap_period_ui=0.

Configuration
REQ-025 With SERVO_PWM_CAP_GLITCH_FILTER_EN defined, the synced level SHALL change only after GLITCH_CLKS consecutive equal samples, event latency 3+GLITCH_CLKS clk; undefined, no filter, latency 3 clk, GLITCH_CLKS unused.

Structure
REQ-026 Package servo_pwm_pkg SHALL hold the width constants (UI width 12, period width 16) and the FSM state typedef.
REQ-027 Synchronizer plus optional filter SHALL be sub-module servo_pwm_pin_sync.

Verification (pulse_ui every 10 clk)
REQ-028 Reset asserted mid-HIGH -> all outputs 0 immediately, IDLE.
REQ-029 Pin high 150 ui / low 1850 ui repeated -> cap_valid once per frame, width=150, period=2000, 3 clk after each rise (filter off).
REQ-030 cap_en raised while pin high -> no cap_valid until second full rise after pin first goes low.
REQ-031 Pin high 5000 ui -> width saturates 4095, cap_error=1, stays 1 until cap_en=0.
REQ-032 Pin low 40000 ui after a frame -> cap_timeout=1, cap_active=0; next two rises -> cap_valid, cap_timeout=0.
REQ-033 2-clk high glitch with filter on -> no event; filter off -> rise and fall events.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared widths, saturation limits, FSM state type and
// saturating-increment helpers for the servo PWM capture block.
package servo_pwm_pkg;

    localparam int UI_W  = 12;   // pulse width counter / output width
    localparam int PER_W = 16;   // period counter / output width

    localparam logic [UI_W-1:0]  UI_MAX  = '1;
    localparam logic [PER_W-1:0] PER_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_HIGH      = 3'd3,
        ST_LOW       = 3'd4
    } state_t;

    function automatic logic [UI_W-1:0] sat_inc_ui(input logic [UI_W-1:0] v);
        return (v == UI_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [PER_W-1:0] sat_inc_per(input logic [PER_W-1:0] v);
        return (v == PER_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/servo_pwm_pin_sync.sv
// servo_pwm_pin_sync: 2-FF synchronizer for the asynchronous PWM pin, an
// optional glitch filter (build with SERVO_PWM_CAP_GLITCH_FILTER_EN), and
// rise/fall detection against a registered copy of the clean level.
// Pin edge to event: 3 clk unfiltered, 3+GLITCH_CLKS clk filtered.
module servo_pwm_pin_sync #(
    parameter int GLITCH_CLKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    // Two-flop synchronizer on the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
        end
    end

`ifdef SERVO_PWM_CAP_GLITCH_FILTER_EN
    localparam int CNT_W = (GLITCH_CLKS > 1) ? $clog2(GLITCH_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CLKS - 1);

    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // Accept a new level only after GLITCH_CLKS consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (r_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    // GLITCH_CLKS only shapes the filter; tie it off in the unfiltered build.
    logic w_unused_glitch;
    assign w_unused_glitch = (GLITCH_CLKS != 0);
    assign w_level         = r_sync;
`endif

    // Delayed copy of the clean level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures high time and rise-to-rise period of a servo
// PWM signal in pulse_ui ticks. Define SERVO_PWM_CAP_GLITCH_FILTER_EN to
// enable the pin glitch filter. A frame is reported only once a complete
// rise-to-rise interval has been seen after arming on a low level.
module servo_pwm_capture
    import servo_pwm_pkg::*;
#(
    parameter int GLITCH_CLKS = 4,
    parameter int TIMEOUT_UI  = 40000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic             pulse_ui,
    input  logic             pwm_pin,
    output logic             cap_active,
    output logic             cap_valid,
    output logic [UI_W-1:0]  cap_pulse_width_ui,
    output logic [PER_W-1:0] cap_period_ui,
    output logic             cap_timeout,
    output logic             cap_error,
    output state_t           o_dbg_state
);

    localparam logic [PER_W-1:0] TIMEOUT_V = PER_W'(TIMEOUT_UI);

    state_t           r_state;
    state_t           w_next_state;
    logic [UI_W-1:0]  r_width;
    logic [PER_W-1:0] r_period;
    logic [UI_W-1:0]  r_width_out;
    logic [PER_W-1:0] r_period_out;
    logic             r_valid;
    logic             r_timeout;
    logic             r_error;

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_timeout_hit;
    logic w_clr_cnt;
    logic w_inc_width;
    logic w_inc_period;
    logic w_capture;
    logic w_set_timeout;
    logic w_clr_flags;

    servo_pwm_pin_sync #(
        .GLITCH_CLKS (GLITCH_CLKS)
    ) u_pin_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (pwm_pin),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_timeout_hit = (r_period >= TIMEOUT_V);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and counter/flag controls; a rise beats a timeout.
    always_comb begin
        w_next_state  = r_state;
        w_clr_cnt     = 1'b0;
        w_inc_width   = 1'b0;
        w_inc_period  = 1'b0;
        w_capture     = 1'b0;
        w_set_timeout = 1'b0;
        w_clr_flags   = 1'b0;
        if (!cap_en) begin
            w_next_state = ST_IDLE;
            w_clr_cnt    = 1'b1;
            w_clr_flags  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_ARM;
                ST_ARM: begin
                    if (!w_level) w_next_state = ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        w_next_state = ST_HIGH;
                        w_clr_cnt    = 1'b1;
                    end else if (w_timeout_hit) begin
                        w_next_state  = ST_ARM;
                        w_clr_cnt     = 1'b1;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_inc_period = pulse_ui;
                    end
                end
                ST_HIGH: begin
                    if (w_timeout_hit) begin
                        w_next_state  = ST_ARM;
                        w_clr_cnt     = 1'b1;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_inc_width  = pulse_ui;
                        w_inc_period = pulse_ui;
                        if (w_fall) w_next_state = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        w_next_state = ST_HIGH;
                        w_capture    = 1'b1;
                        w_clr_cnt    = 1'b1;
                    end else if (w_timeout_hit) begin
                        w_next_state  = ST_ARM;
                        w_clr_cnt     = 1'b1;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_inc_period = pulse_ui;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Width and period counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width  <= '0;
            r_period <= '0;
        end else if (w_clr_cnt) begin
            r_width  <= '0;
            r_period <= '0;
        end else begin
            if (w_inc_width)  r_width  <= sat_inc_ui(r_width);
            if (w_inc_period) r_period <= sat_inc_per(r_period);
        end
    end

    // Measurement outputs, valid strobe, timeout and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width_out  <= '0;
            r_period_out <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_width_out  <= r_width;
                r_period_out <= r_period;
            end
            if (w_clr_flags) begin
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else if (w_capture) begin
                r_timeout <= 1'b0;
            end
            if (w_clr_flags) begin
                r_error <= 1'b0;
            end else if ((r_width == UI_MAX) || (r_period == PER_MAX)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign cap_active         = (r_state == ST_HIGH) || (r_state == ST_LOW);
    assign cap_valid          = r_valid;
    assign cap_pulse_width_ui = r_width_out;
    assign cap_period_ui      = r_period_out;
    assign cap_timeout        = r_timeout;
    assign cap_error          = r_error;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb_servo_pwm_capture: directed, table-driven bench. The pin is driven in
// segments of whole ui; each ui starts with a pulse_ui tick coincident with
// the pin level being applied, so counts come out as exact ui numbers.
module tb_servo_pwm_capture;
    import servo_pwm_pkg::*;

    localparam int TO_UI = 5100;
`ifdef SERVO_PWM_CAP_GLITCH_FILTER_EN
    localparam int GLITCH = 4;
    localparam int LAT    = 3 + GLITCH;
    localparam int FAST   = 5;
`else
    localparam int GLITCH = 4;
    localparam int LAT    = 3;
    localparam int FAST   = 3;
`endif

    typedef struct {
        logic lvl;
        int   n_ui;
        int   div;
        int   exp_valids;
        int   exp_w;
        int   exp_p;
        logic exp_active;
        logic exp_to;
        logic exp_err;
    } seg_t;

    logic             clk;
    logic             rst_n;
    logic             cap_en;
    logic             pulse_ui;
    logic             pwm_pin;
    logic             cap_active;
    logic             cap_valid;
    logic [UI_W-1:0]  cap_pulse_width_ui;
    logic [PER_W-1:0] cap_period_ui;
    logic             cap_timeout;
    logic             cap_error;
    state_t           dbg_state;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int last_rise_cyc = 0;

    seg_t segs[15];

    servo_pwm_capture #(
        .GLITCH_CLKS (GLITCH),
        .TIMEOUT_UI  (TO_UI)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cap_en             (cap_en),
        .pulse_ui           (pulse_ui),
        .pwm_pin            (pwm_pin),
        .cap_active         (cap_active),
        .cap_valid          (cap_valid),
        .cap_pulse_width_ui (cap_pulse_width_ui),
        .cap_period_ui      (cap_period_ui),
        .cap_timeout        (cap_timeout),
        .cap_error          (cap_error),
        .o_dbg_state        (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: count valid strobes and check rise-to-valid latency.
    always @(negedge clk) begin
        if (rst_n && cap_valid) begin
            valid_cnt <= valid_cnt + 1;
            chk("valid_latency", cyc - last_rise_cyc, LAT);
        end
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seg(input logic lvl, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            if (lvl && !pwm_pin) last_rise_cyc = cyc;
            pwm_pin  = lvl;
            pulse_ui = 1'b1;
            tick_clk();
            pulse_ui = 1'b0;
            for (int k = 1; k < div; k++) tick_clk();
        end
    endtask

    // Bound the whole run in case something stalls.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        //            lvl   n_ui  div   vld  w     p     act   to    err
        segs[0]  = '{1'b1,   30,   10,   0,    0,    0, 1'b0, 1'b0, 1'b0}; // pulse in progress at enable
        segs[1]  = '{1'b0,  100,   10,   0,    0,    0, 1'b0, 1'b0, 1'b0};
        segs[2]  = '{1'b1,  150,   10,   0,    0,    0, 1'b1, 1'b0, 1'b0}; // first rise: not reported
        segs[3]  = '{1'b0, 1850,   10,   0,    0,    0, 1'b1, 1'b0, 1'b0};
        segs[4]  = '{1'b1,  150,   10,   1,  150, 2000, 1'b1, 1'b0, 1'b0};
        segs[5]  = '{1'b0, 1850,   10,   0,  150, 2000, 1'b1, 1'b0, 1'b0};
        segs[6]  = '{1'b1,  150,   10,   1,  150, 2000, 1'b1, 1'b0, 1'b0};
        segs[7]  = '{1'b0, 5300, FAST,   0,  150, 2000, 1'b0, 1'b1, 1'b0}; // times out
        segs[8]  = '{1'b1,  100, FAST,   0,  150, 2000, 1'b1, 1'b1, 1'b0};
        segs[9]  = '{1'b0,  200, FAST,   0,  150, 2000, 1'b1, 1'b1, 1'b0};
        segs[10] = '{1'b1,   20, FAST,   1,  100,  300, 1'b1, 1'b0, 1'b0};
        segs[11] = '{1'b0,   50, FAST,   0,  100,  300, 1'b1, 1'b0, 1'b0};
        segs[12] = '{1'b1, 5000, FAST,   1,   20,   70, 1'b1, 1'b0, 1'b1}; // width saturates
        segs[13] = '{1'b0,   40, FAST,   0,   20,   70, 1'b1, 1'b0, 1'b1};
        segs[14] = '{1'b1,   10, FAST,   1, 4095, 5040, 1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        cap_en   = 1'b0;
        pulse_ui = 1'b0;
        pwm_pin  = 1'b0;
        repeat (3) tick_clk();
        chk("rst_active", int'(cap_active), 0);
        chk("rst_valid", int'(cap_valid), 0);
        chk("rst_width", int'(cap_pulse_width_ui), 0);
        chk("rst_period", int'(cap_period_ui), 0);
        chk("rst_timeout", int'(cap_timeout), 0);
        chk("rst_error", int'(cap_error), 0);
        chk("rst_state", int'(dbg_state), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) tick_clk();

        // Two-clock high glitch while waiting for a rise.
        cap_en = 1'b1;
        repeat (6) tick_clk();
        chk("glitch_pre_state", int'(dbg_state), int'(ST_WAIT_RISE));
        pwm_pin = 1'b1;
        repeat (2) tick_clk();
        pwm_pin = 1'b0;
        repeat (12) tick_clk();
`ifdef SERVO_PWM_CAP_GLITCH_FILTER_EN
        chk("glitch_state", int'(dbg_state), int'(ST_WAIT_RISE));
        chk("glitch_active", int'(cap_active), 0);
`else
        chk("glitch_state", int'(dbg_state), int'(ST_LOW));
        chk("glitch_active", int'(cap_active), 1);
`endif
        cap_en = 1'b0;
        repeat (2) tick_clk();
        chk("disable_state", int'(dbg_state), int'(ST_IDLE));
        chk("disable_active", int'(cap_active), 0);

        // Enable while the pin is already high, then walk the segment table.
        pwm_pin = 1'b1;
        repeat (5) tick_clk();
        cap_en = 1'b1;
        for (int s = 0; s < 15; s++) begin
            v0 = valid_cnt;
            run_seg(segs[s].lvl, segs[s].n_ui, segs[s].div);
            chk($sformatf("seg%0d_valids", s), valid_cnt - v0, segs[s].exp_valids);
            chk($sformatf("seg%0d_width", s), int'(cap_pulse_width_ui), segs[s].exp_w);
            chk($sformatf("seg%0d_period", s), int'(cap_period_ui), segs[s].exp_p);
            chk($sformatf("seg%0d_active", s), int'(cap_active), int'(segs[s].exp_active));
            chk($sformatf("seg%0d_timeout", s), int'(cap_timeout), int'(segs[s].exp_to));
            chk($sformatf("seg%0d_error", s), int'(cap_error), int'(segs[s].exp_err));
        end

        // Dropping cap_en clears flags but holds the last measurement.
        cap_en = 1'b0;
        repeat (2) tick_clk();
        chk("off_error", int'(cap_error), 0);
        chk("off_timeout", int'(cap_timeout), 0);
        chk("off_active", int'(cap_active), 0);
        chk("off_state", int'(dbg_state), int'(ST_IDLE));
        chk("off_width_hold", int'(cap_pulse_width_ui), 4095);
        chk("off_period_hold", int'(cap_period_ui), 5040);

        // Asynchronous reset in the middle of a high pulse.
        cap_en  = 1'b1;
        pwm_pin = 1'b0;
        repeat (5) tick_clk();
        last_rise_cyc = cyc;
        pwm_pin = 1'b1;
        repeat (5) tick_clk();
        chk("pre_rst_state", int'(dbg_state), int'(ST_HIGH));
        chk("pre_rst_active", int'(cap_active), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(dbg_state), int'(ST_IDLE));
        chk("async_rst_active", int'(cap_active), 0);
        chk("async_rst_valid", int'(cap_valid), 0);
        chk("async_rst_width", int'(cap_pulse_width_ui), 0);
        chk("async_rst_period", int'(cap_period_ui), 0);
        chk("async_rst_timeout", int'(cap_timeout), 0);
        chk("async_rst_error", int'(cap_error), 0);
        repeat (2) tick_clk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
